// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes seen by the D/E
// decoders, FSM state encoding and default latencies.
package mdu_pkg;

    localparam logic [2:0] MDU_NONE  = 3'd0;
    localparam logic [2:0] MDU_MULT  = 3'd1;
    localparam logic [2:0] MDU_MULTU = 3'd2;
    localparam logic [2:0] MDU_DIV   = 3'd3;
    localparam logic [2:0] MDU_DIVU  = 3'd4;
    localparam logic [2:0] MDU_MTHI  = 3'd5;
    localparam logic [2:0] MDU_MTLO  = 3'd6;
    localparam logic [2:0] MDU_RSVD  = 3'd7;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_t;

    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_mult(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational datapath: signed/unsigned product and quotient/remainder
// for the MDU, with divide-by-zero flagged and INT_MIN / -1 handled.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_by_zero
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] divisor;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;
    logic               overflow;

    always_comb begin
        prod_s      = $signed(srcA) * $signed(srcB);
        prod_u      = {32'd0, srcA} * {32'd0, srcB};
        div_by_zero = ((op == MDU_DIV) || (op == MDU_DIVU)) && (srcB == 32'd0);
        // A zero divisor is swapped for 1 so the dividers never see it; the
        // result is discarded at commit anyway.
        divisor     = (srcB == 32'd0) ? 32'd1 : srcB;
        overflow    = (srcA == 32'h8000_0000) && (srcB == 32'hFFFF_FFFF);
        if (overflow) begin
            quo_s = 32'sh8000_0000;
            rem_s = 32'sd0;
        end else begin
            quo_s = $signed(srcA) / $signed(divisor);
            rem_s = $signed(srcA) % $signed(divisor);
        end
        quo_u = srcA / divisor;
        rem_u = srcA % divisor;

        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op)
            MDU_MULT:  {res_hi, res_lo} = prod_s;
            MDU_MULTU: {res_hi, res_lo} = prod_u;
            MDU_DIV: begin
                res_hi = rem_s;
                res_lo = quo_s;
            end
            MDU_DIVU: begin
                res_hi = rem_u;
                res_lo = quo_u;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// E-stage multiply/divide unit: holds HI/LO, models the multi-cycle latency
// with a countdown, and raises busy so the stall unit holds dependents in D.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_t  state, next_state;
    logic        launch;
    logic        commit;
    logic [31:0] count;
    logic [31:0] pending_hi;
    logic [31:0] pending_lo;
    logic        pending_dbz;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        div_by_zero;

    mdu_calc u_calc (
        .op          (op),
        .srcA        (srcA),
        .srcB        (srcB),
        .res_hi      (res_hi),
        .res_lo      (res_lo),
        .div_by_zero (div_by_zero)
    );

    always_comb begin
        next_state = state;
        launch     = 1'b0;
        commit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && is_muldiv(op)) begin
                    next_state = ST_RUN;
                    launch     = 1'b1;
                end
            end
            ST_RUN: begin
                if (count == 32'd1) begin
                    next_state = ST_IDLE;
                    commit     = 1'b1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The result is captured at launch so operands may change while busy;
    // starts arriving during RUN fall through every branch and are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy        <= 1'b0;
            hi          <= 32'd0;
            lo          <= 32'd0;
            count       <= 32'd0;
            pending_hi  <= 32'd0;
            pending_lo  <= 32'd0;
            pending_dbz <= 1'b0;
        end else if (launch) begin
            busy        <= 1'b1;
            pending_hi  <= res_hi;
            pending_lo  <= res_lo;
            pending_dbz <= div_by_zero;
            count       <= is_mult(op) ? 32'(MULT_CYCLES) : 32'(DIV_CYCLES);
        end else if (state == ST_RUN) begin
            count <= count - 32'd1;
            if (commit) begin
                busy <= 1'b0;
                if (!pending_dbz) begin
                    hi <= pending_hi;
                    lo <= pending_lo;
                end
            end
        end else if (start && (op == MDU_MTHI)) begin
            hi <= srcA;
        end else if (start && (op == MDU_MTLO)) begin
            lo <= srcA;
        end
    end

endmodule
